wb_stage: RTL

Writeback stage sitting directly upstream of the register file's write port (`rf_write_reg` / `rf_reg_in` / `rf_write_data`). It merges single-cycle ALU results with out-of-order-in-time (but in-order) load responses into one registered RF write per cycle. It tracks outstanding load destinations in a small in-order tag queue and exposes a hazard query so decode can stall on registers whose values are not yet written.

---
 rtl/wb_stage.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// wb_stage: writeback stage feeding the register file write port.
// Merges single-cycle ALU results with in-order load responses into one
// registered RF write per cycle. Outstanding load destinations are kept in a
// small circular tag queue, which also backs the decode hazard query.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   alu_wr_valid/reg/data          ALU result; alu_stall=1 means not consumed
//   ld_issue_valid/reg             load issue (pushes destination tag)
//   ld_rsp_valid/data              load response (pairs with head tag)
//   lq_full                        tag queue holds LQ_DEPTH entries
//   hz_reg / hz_busy               hazard query: pending write to hz_reg
//   err_overflow / err_underflow   sticky queue error flags
//   rf_write_reg/rf_reg_in/rf_write_data  registered RF write
module wb_stage #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned NUM_REGS = 14,
    parameter int unsigned LQ_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_wr_valid,
    input  logic [ADDR_W-1:0] alu_wr_reg,
    input  logic [DATA_W-1:0] alu_wr_data,
    output logic              alu_stall,
    input  logic              ld_issue_valid,
    input  logic [ADDR_W-1:0] ld_issue_reg,
    input  logic              ld_rsp_valid,
    input  logic [DATA_W-1:0] ld_rsp_data,
    output logic              lq_full,
    input  logic [ADDR_W-1:0] hz_reg,
    output logic              hz_busy,
    output logic              err_overflow,
    output logic              err_underflow,
    output logic              rf_write_reg,
    output logic [ADDR_W-1:0] rf_reg_in,
    output logic [DATA_W-1:0] rf_write_data
);

    localparam int unsigned PtrW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(LQ_DEPTH + 1);

    logic [ADDR_W-1:0] tags_q [LQ_DEPTH];
    logic [PtrW-1:0]   head_q, head_d;
    logic [PtrW-1:0]   tail_q, tail_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] reg_q, reg_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic              q_empty, q_full;
    logic              pop, push;
    logic              win_valid;
    logic [ADDR_W-1:0] win_reg;
    logic [DATA_W-1:0] win_data;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (int'(p) == int'(LQ_DEPTH) - 1) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign q_empty = (count_q == '0);
    assign q_full  = (count_q == CntW'(LQ_DEPTH));

    // No same-cycle bypass: a response is only valid against tags already queued.
    assign pop  = ld_rsp_valid && !q_empty;
    // A full queue still accepts a push when the head is leaving this cycle.
    assign push = ld_issue_valid && (!q_full || pop);

    assign alu_stall = alu_wr_valid && pop;
    assign lq_full   = q_full;

    always_comb begin
        win_valid = 1'b0;
        win_reg   = '0;
        win_data  = '0;
        if (pop) begin
            win_valid = 1'b1;
            win_reg   = tags_q[head_q];
            win_data  = ld_rsp_data;
        end else if (alu_wr_valid) begin
            win_valid = 1'b1;
            win_reg   = alu_wr_reg;
            win_data  = alu_wr_data;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        wr_d    = 1'b0;
        reg_d   = reg_q;
        data_d  = data_q;

        if (pop) begin
            head_d = ptr_inc(head_q);
        end
        if (push) begin
            tail_d = ptr_inc(tail_q);
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        if (ld_issue_valid && !push) begin
            ovf_d = 1'b1;
        end
        if (ld_rsp_valid && q_empty) begin
            udf_d = 1'b1;
        end

        // Out-of-range index consumes the slot but never reaches the RF.
        if (win_valid && (int'(win_reg) < int'(NUM_REGS))) begin
            wr_d   = 1'b1;
            reg_d  = win_reg;
            data_d = win_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(LQ_DEPTH); i++) begin
                tags_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            wr_q    <= 1'b0;
            reg_q   <= '0;
            data_q  <= '0;
        end else begin
            if (push) begin
                tags_q[tail_q] <= ld_issue_reg;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            wr_q    <= wr_d;
            reg_q   <= reg_d;
            data_q  <= data_d;
        end
    end

    // Busy if any live queue entry targets hz_reg, or the RF write is in flight.
    always_comb begin
        int j;
        j       = 0;
        hz_busy = wr_q && (reg_q == hz_reg);
        for (int k = 0; k < int'(LQ_DEPTH); k++) begin
            if (k < int'(count_q)) begin
                j = int'(head_q) + k;
                if (j >= int'(LQ_DEPTH)) begin
                    j = j - int'(LQ_DEPTH);
                end
                if (tags_q[PtrW'(j)] == hz_reg) begin
                    hz_busy = 1'b1;
                end
            end
        end
    end

    assign err_overflow  = ovf_q;
    assign err_underflow = udf_q;
    assign rf_write_reg  = wr_q;
    assign rf_reg_in     = reg_q;
    assign rf_write_data = data_q;

endmodule
